// File: rtl/smbus_ioexp_regctl.sv
// PCA9555-style register file behind the SMBus IO-expander slave: own register pointer,
// host/local write arbitration, input synchronizer and snapshot-based change interrupt.
module smbus_ioexp_regctl #(
  parameter logic [15:0] OUT_RST = 16'hFFFF,
  parameter logic [15:0] POL_RST = 16'h0000,
  parameter logic [15:0] CFG_RST = 16'hFFFF
) (
  input  logic        CLK_IN,
  input  logic        RESET_N,
  input  logic [7:0]  OFFSET,
  input  logic [7:0]  DATA_OUT,
  input  logic        WRITE_EN,
  input  logic        READ_EN,
  output logic [7:0]  DATA_IN,
  input  logic [15:0] GPIO_IN,
  output logic [15:0] GPIO_OUT,
  output logic [15:0] GPIO_OE,
  output logic        INT_N,
  input  logic        LOC_WR_REQ,
  input  logic [2:0]  LOC_ADDR,
  input  logic [7:0]  LOC_WDATA,
  output logic        LOC_WR_ACK
);

  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  off_q, off_d;
  logic [15:0] out_q, out_d;
  logic [15:0] pol_q, pol_d;
  logic [15:0] cfg_q, cfg_d;
  logic [15:0] gin_m_q, gin_s_q;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        int_n_q, int_n_d;
  logic        ack_q, ack_d;

  logic        ptr_valid;
  logic        loc_grant;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_byte;

  assign ptr_valid = (ptr_q[7:3] == 5'd0);

  always_comb begin
    rd_byte = 8'hFF;
    if (ptr_valid) begin
      case (ptr_q[2:0])
        3'd0:    rd_byte = gin_s_q[7:0]  ^ pol_q[7:0];
        3'd1:    rd_byte = gin_s_q[15:8] ^ pol_q[15:8];
        3'd2:    rd_byte = out_q[7:0];
        3'd3:    rd_byte = out_q[15:8];
        3'd4:    rd_byte = pol_q[7:0];
        3'd5:    rd_byte = pol_q[15:8];
        3'd6:    rd_byte = cfg_q[7:0];
        default: rd_byte = cfg_q[15:8];
      endcase
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    off_d     = OFFSET;
    out_d     = out_q;
    pol_d     = pol_q;
    cfg_d     = cfg_q;
    snap_d    = snap_q;
    data_in_d = data_in_q;
    wr_en     = 1'b0;
    wr_addr   = 3'd0;
    wr_data   = 8'h00;

    // ack_q masks the grant so a requester still holding REQ during ACK is not served twice.
    loc_grant = LOC_WR_REQ & ~WRITE_EN & ~ack_q;
    ack_d     = loc_grant;

    if (WRITE_EN) begin
      if (ptr_valid) begin
        wr_en   = 1'b1;
        wr_addr = ptr_q[2:0];
        wr_data = DATA_OUT;
      end
    end else if (loc_grant) begin
      wr_en   = 1'b1;
      wr_addr = LOC_ADDR;
      wr_data = LOC_WDATA;
    end

    // Addresses 0/1 are the read-only input port: such writes fall through the case.
    if (wr_en) begin
      case (wr_addr)
        3'd2:    out_d[7:0]  = wr_data;
        3'd3:    out_d[15:8] = wr_data;
        3'd4:    pol_d[7:0]  = wr_data;
        3'd5:    pol_d[15:8] = wr_data;
        3'd6:    cfg_d[7:0]  = wr_data;
        3'd7:    cfg_d[15:8] = wr_data;
        default: ;
      endcase
    end

    if (READ_EN && !WRITE_EN) begin
      data_in_d = rd_byte;
      if (ptr_q == 8'd0) snap_d[7:0]  = gin_s_q[7:0];
      if (ptr_q == 8'd1) snap_d[15:8] = gin_s_q[15:8];
    end

    if ((OFFSET != 8'hFF) && (OFFSET != off_q)) begin
      ptr_d = OFFSET;
    end else if ((WRITE_EN || READ_EN) && ptr_valid) begin
      ptr_d = ptr_q ^ 8'h01;
    end

    int_n_d = ~|((gin_s_q ^ snap_q) & cfg_q);
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q     <= 8'h00;
      off_q     <= 8'hFF;
      out_q     <= OUT_RST;
      pol_q     <= POL_RST;
      cfg_q     <= CFG_RST;
      gin_m_q   <= 16'hFFFF;
      gin_s_q   <= 16'hFFFF;
      snap_q    <= 16'hFFFF;
      data_in_q <= 8'hFF;
      int_n_q   <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      off_q     <= off_d;
      out_q     <= out_d;
      pol_q     <= pol_d;
      cfg_q     <= cfg_d;
      gin_m_q   <= GPIO_IN;
      gin_s_q   <= gin_m_q;
      snap_q    <= snap_d;
      data_in_q <= data_in_d;
      int_n_q   <= int_n_d;
      ack_q     <= ack_d;
    end
  end

  assign DATA_IN    = data_in_q;
  assign GPIO_OUT   = out_q;
  assign GPIO_OE    = ~cfg_q;
  assign INT_N      = int_n_q;
  assign LOC_WR_ACK = ack_q;

endmodule

// File: tb/tb_smbus_ioexp_regctl.sv
// Bench for smbus_ioexp_regctl: directed scenarios plus random host/local/pin traffic
// checked against a byte-array model of the register map.
module tb_smbus_ioexp_regctl;

  localparam logic [15:0] OUT_RST = 16'hFFFF;
  localparam logic [15:0] POL_RST = 16'h0000;
  localparam logic [15:0] CFG_RST = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  offset = 8'hFF;
  logic [7:0]  data_out = 8'h00;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [7:0]  data_in;
  logic [15:0] gpio_in = 16'hFFFF;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        int_n;
  logic        loc_wr_req = 1'b0;
  logic [2:0]  loc_addr = 3'd0;
  logic [7:0]  loc_wdata = 8'h00;
  logic        loc_wr_ack;

  always #5 clk = ~clk;

  smbus_ioexp_regctl #(.OUT_RST(OUT_RST), .POL_RST(POL_RST), .CFG_RST(CFG_RST)) dut (
    .CLK_IN(clk), .RESET_N(rst_n), .OFFSET(offset), .DATA_OUT(data_out),
    .WRITE_EN(write_en), .READ_EN(read_en), .DATA_IN(data_in), .GPIO_IN(gpio_in),
    .GPIO_OUT(gpio_out), .GPIO_OE(gpio_oe), .INT_N(int_n), .LOC_WR_REQ(loc_wr_req),
    .LOC_ADDR(loc_addr), .LOC_WDATA(loc_wdata), .LOC_WR_ACK(loc_wr_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register map as bytes indexed by address, plus pointer and snapshot.
  logic [7:0]  m_reg [8];
  int          m_ptr;
  logic [15:0] m_snap;
  logic [15:0] m_pins = 16'hFFFF;
  logic [7:0]  m_data_in;

  function automatic logic [15:0] m_out();
    return {m_reg[3], m_reg[2]};
  endfunction

  function automatic logic [15:0] m_cfg();
    return {m_reg[7], m_reg[6]};
  endfunction

  function automatic logic m_int_n();
    return ~|((m_pins ^ m_snap) & m_cfg());
  endfunction

  function automatic logic [7:0] m_read_byte(int p);
    if (p >= 8) return 8'hFF;
    if (p == 0) return m_pins[7:0] ^ m_reg[4];
    if (p == 1) return m_pins[15:8] ^ m_reg[5];
    return m_reg[p];
  endfunction

  task automatic model_reset();
    m_reg[0] = 8'h00; m_reg[1] = 8'h00;
    m_reg[2] = OUT_RST[7:0]; m_reg[3] = OUT_RST[15:8];
    m_reg[4] = POL_RST[7:0]; m_reg[5] = POL_RST[15:8];
    m_reg[6] = CFG_RST[7:0]; m_reg[7] = CFG_RST[15:8];
    m_ptr = 0;
    m_snap = 16'hFFFF;
    m_data_in = 8'hFF;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv_ptr(int p);
    offset = p[7:0];
    step(1);
    offset = 8'hFF;
    step(1);
    m_ptr = p;
  endtask

  task automatic drv_write(logic [7:0] d);
    data_out = d;
    write_en = 1'b1;
    step(1);
    write_en = 1'b0;
    if (m_ptr >= 2 && m_ptr <= 7) m_reg[m_ptr] = d;
    if (m_ptr < 8) m_ptr = m_ptr ^ 1;
  endtask

  task automatic drv_read();
    read_en = 1'b1;
    step(1);
    read_en = 1'b0;
    m_data_in = m_read_byte(m_ptr);
    if (m_ptr == 0) m_snap[7:0] = m_pins[7:0];
    if (m_ptr == 1) m_snap[15:8] = m_pins[15:8];
    if (m_ptr < 8) m_ptr = m_ptr ^ 1;
  endtask

  task automatic drv_pins(logic [15:0] v);
    gpio_in = v;
    m_pins = v;
  endtask

  task automatic drv_local(logic [2:0] a, logic [7:0] d);
    logic got;
    loc_addr = a;
    loc_wdata = d;
    loc_wr_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(1);
      if (loc_wr_ack === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL loc_ack_timeout: got no ack, expected ack within 8 cycles");
    end
    // REQ stays high for the ACK cycle; a second grant would show as a stretched ACK.
    step(1);
    n_checks++;
    if (loc_wr_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL loc_ack_pulse: got %b expected 0", loc_wr_ack);
    end
    loc_wr_req = 1'b0;
    if (a >= 2) m_reg[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    step(2);
    n_checks++;
    if (gpio_out !== 16'hFFFF) begin n_errors++; $display("FAIL reset_gpio_out: got %h expected ffff", gpio_out); end
    n_checks++;
    if (gpio_oe !== 16'h0000) begin n_errors++; $display("FAIL reset_gpio_oe: got %h expected 0000", gpio_oe); end
    n_checks++;
    if (int_n !== 1'b1) begin n_errors++; $display("FAIL reset_int_n: got %b expected 1", int_n); end
    n_checks++;
    if (data_in !== 8'hFF) begin n_errors++; $display("FAIL reset_data_in: got %h expected ff", data_in); end
    n_checks++;
    if (loc_wr_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", loc_wr_ack); end
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_out_write();
    drv_ptr(2);
    drv_write(8'h5A);
    n_checks++;
    if (gpio_out !== 16'hFF5A) begin n_errors++; $display("FAIL out_write_lo: got %h expected ff5a", gpio_out); end
    drv_write(8'hA5);
    n_checks++;
    if (gpio_out !== 16'hA55A) begin n_errors++; $display("FAIL out_write_hi: got %h expected a55a", gpio_out); end
    step(1);
    drv_read();
    n_checks++;
    if (data_in !== 8'h5A) begin n_errors++; $display("FAIL out_ptr_wrap: got %h expected 5a", data_in); end
  endtask

  task automatic test_cfg_mask();
    drv_ptr(6);
    drv_write(8'h00);
    n_checks++;
    if (gpio_oe !== 16'h00FF) begin n_errors++; $display("FAIL cfg_oe: got %h expected 00ff", gpio_oe); end
    drv_pins(16'hFFFE);
    step(4);
    n_checks++;
    if (int_n !== 1'b1) begin n_errors++; $display("FAIL cfg_output_no_int: got %b expected 1", int_n); end
  endtask

  task automatic test_int_snapshot();
    drv_pins(16'hFEFE);
    step(2);
    n_checks++;
    if (int_n !== 1'b1) begin n_errors++; $display("FAIL int_early: got %b expected 1", int_n); end
    step(1);
    n_checks++;
    if (int_n !== 1'b0) begin n_errors++; $display("FAIL int_latency: got %b expected 0", int_n); end
    drv_ptr(1);
    drv_read();
    n_checks++;
    if (data_in !== 8'hFE) begin n_errors++; $display("FAIL int_read_hi: got %h expected fe", data_in); end
    n_checks++;
    if (int_n !== 1'b0) begin n_errors++; $display("FAIL int_hold: got %b expected 0", int_n); end
    step(1);
    n_checks++;
    if (int_n !== 1'b1) begin n_errors++; $display("FAIL int_clear: got %b expected 1", int_n); end
  endtask

  task automatic test_polarity();
    drv_ptr(4);
    drv_write(8'hFF);
    drv_pins(16'hFFF0);
    step(4);
    drv_ptr(0);
    drv_read();
    n_checks++;
    if (data_in !== 8'h0F) begin n_errors++; $display("FAIL pol_read_lo: got %h expected 0f", data_in); end
    step(1);
    drv_read();
    n_checks++;
    if (data_in !== 8'hFF) begin n_errors++; $display("FAIL pol_read_hi: got %h expected ff", data_in); end
  endtask

  task automatic test_local_arb();
    drv_ptr(3);
    data_out = 8'h34;
    write_en = 1'b1;
    loc_addr = 3'd3;
    loc_wdata = 8'h12;
    loc_wr_req = 1'b1;
    step(1);
    write_en = 1'b0;
    n_checks++;
    if (gpio_out[15:8] !== 8'h34) begin n_errors++; $display("FAIL arb_host_first: got %h expected 34", gpio_out[15:8]); end
    n_checks++;
    if (loc_wr_ack !== 1'b0) begin n_errors++; $display("FAIL arb_ack_wait: got %b expected 0", loc_wr_ack); end
    step(1);
    n_checks++;
    if (loc_wr_ack !== 1'b1) begin n_errors++; $display("FAIL arb_ack: got %b expected 1", loc_wr_ack); end
    n_checks++;
    if (gpio_out[15:8] !== 8'h12) begin n_errors++; $display("FAIL arb_local_data: got %h expected 12", gpio_out[15:8]); end
    loc_wr_req = 1'b0;
    step(1);
    n_checks++;
    if (loc_wr_ack !== 1'b0) begin n_errors++; $display("FAIL arb_ack_pulse: got %b expected 0", loc_wr_ack); end
    m_reg[3] = 8'h12;
    m_ptr = 2;
  endtask

  task automatic test_invalid_ptr();
    drv_ptr(9);
    drv_read();
    n_checks++;
    if (data_in !== 8'hFF) begin n_errors++; $display("FAIL inv_read: got %h expected ff", data_in); end
    drv_write(8'h77);
    n_checks++;
    if (gpio_out !== m_out()) begin n_errors++; $display("FAIL inv_write_drop: got %h expected %h", gpio_out, m_out()); end
    drv_ptr(0);
    drv_write(8'h55);
    n_checks++;
    if (gpio_oe !== ~m_cfg()) begin n_errors++; $display("FAIL ro_write_drop: got %h expected %h", gpio_oe, ~m_cfg()); end
    step(1);
    drv_read();
    n_checks++;
    if (data_in !== m_data_in) begin n_errors++; $display("FAIL ro_ptr_advance: got %h expected %h", data_in, m_data_in); end
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: drv_ptr(($urandom_range(0, 7) == 0) ? $urandom_range(8, 254) : $urandom_range(0, 7));
        1: drv_write(8'($urandom_range(0, 255)));
        2: drv_read();
        3: drv_local(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        4: drv_pins(16'($urandom_range(0, 65535)));
        default: drv_pins(m_snap ^ (16'h1 << $urandom_range(0, 15)));
      endcase
      step(4);
      n_checks++;
      if (gpio_out !== m_out()) begin n_errors++; $display("FAIL rnd_gpio_out it=%0d: got %h expected %h", it, gpio_out, m_out()); end
      n_checks++;
      if (gpio_oe !== ~m_cfg()) begin n_errors++; $display("FAIL rnd_gpio_oe it=%0d: got %h expected %h", it, gpio_oe, ~m_cfg()); end
      n_checks++;
      if (int_n !== m_int_n()) begin n_errors++; $display("FAIL rnd_int_n it=%0d: got %b expected %b", it, int_n, m_int_n()); end
      n_checks++;
      if (data_in !== m_data_in) begin n_errors++; $display("FAIL rnd_data_in it=%0d: got %h expected %h", it, data_in, m_data_in); end
    end
  endtask

  task automatic test_reset_mid();
    drv_pins(16'hFFFF);
    drv_ptr(2);
    data_out = 8'h00;
    write_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gpio_out !== OUT_RST) begin n_errors++; $display("FAIL midrst_gpio_out: got %h expected %h", gpio_out, OUT_RST); end
    n_checks++;
    if (gpio_oe !== ~CFG_RST) begin n_errors++; $display("FAIL midrst_gpio_oe: got %h expected %h", gpio_oe, ~CFG_RST); end
    n_checks++;
    if (data_in !== 8'hFF) begin n_errors++; $display("FAIL midrst_data_in: got %h expected ff", data_in); end
    step(1);
    write_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(4);
    n_checks++;
    if (gpio_out !== 16'hFFFF) begin n_errors++; $display("FAIL midrst_no_commit: got %h expected ffff", gpio_out); end
    n_checks++;
    if (int_n !== m_int_n()) begin n_errors++; $display("FAIL midrst_int_n: got %b expected %b", int_n, m_int_n()); end
    drv_read();
    n_checks++;
    if (data_in !== m_data_in) begin n_errors++; $display("FAIL midrst_ptr_zero: got %h expected %h", data_in, m_data_in); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_out_write();
    test_cfg_mask();
    test_int_snapshot();
    test_polarity();
    test_local_arb();
    test_invalid_ptr();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
